// File: rtl/fetch_prefetch_if.sv
// Fetch-unit bus bundle: execute redirect, instruction-memory request/response
// and decode handoff. master = fetcher, slave = surrounding pipeline/memory.
interface fetch_prefetch_if #(
    parameter int XLEN = 32
);
    logic            pc_ex_valid;
    logic [XLEN-1:0] pc_ex_base;
    logic [XLEN-1:0] pc_ex_off;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-3:0] mem_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            de_valid;
    logic            de_ready;
    logic [XLEN-1:0] de_insn;
    logic [XLEN-1:0] de_pc;

    modport master (
        input  pc_ex_valid, pc_ex_base, pc_ex_off,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, de_ready,
        output mem_req_valid, mem_addr, de_valid, de_insn, de_pc
    );

    modport slave (
        output pc_ex_valid, pc_ex_base, pc_ex_off,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, de_ready,
        input  mem_req_valid, mem_addr, de_valid, de_insn, de_pc
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching instruction fetcher: sequential word requests, DEPTH-entry
// {pc, insn} queue toward decode, redirect flush with in-flight squash.
module fetch_prefetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] ENTRYPOINT = XLEN'(32'h140),
    parameter int              DEPTH      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    fetch_prefetch_if.master        io_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_occ;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_drop;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [XLEN-1:0] r_q_insn [DEPTH];

    logic [CW:0]     w_inflight;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_out_next;

    assign w_inflight  = {1'b0, r_occ} + {1'b0, r_out};
    assign w_redirect  = io_bus.pc_ex_valid;
    assign w_req_valid = !i_rst && !w_redirect && (w_inflight < DEPTH_W);
    assign w_req_fire  = w_req_valid && io_bus.mem_req_ready;
    assign w_target    = io_bus.pc_ex_base + io_bus.pc_ex_off;
    assign w_push      = io_bus.mem_rsp_valid && (r_drop == '0) && !w_redirect;
    assign w_pop       = (r_occ != '0) && io_bus.de_ready && !w_redirect;
    assign w_out_next  = r_out + CW'(w_req_fire) - CW'(io_bus.mem_rsp_valid);

    assign io_bus.mem_req_valid = w_req_valid;
    assign io_bus.mem_addr      = r_pc[XLEN-1:2];
    assign io_bus.de_valid      = (r_occ != '0);
    assign io_bus.de_insn       = r_q_insn[r_rd];
    assign io_bus.de_pc         = r_q_pc[r_rd];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc     <= ENTRYPOINT;
            r_rsp_pc <= ENTRYPOINT;
            r_occ    <= '0;
            r_out    <= '0;
            r_drop   <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_insn[i] <= '0;
            end
        end else begin
            r_out <= w_out_next;
            if (w_redirect) begin
                // Everything still outstanding after this edge belongs to the old path.
                r_pc     <= w_target;
                r_rsp_pc <= w_target;
                r_occ    <= '0;
                r_rd     <= '0;
                r_wr     <= '0;
                r_drop   <= w_out_next;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (io_bus.mem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_push) begin
                    r_q_pc[r_wr]   <= r_rsp_pc;
                    r_q_insn[r_wr] <= io_bus.mem_rsp_data;
                    r_wr           <= r_wr + AW'(1);
                    r_rsp_pc       <= r_rsp_pc + XLEN'(4);
                end
                if (w_pop) begin
                    r_rd <= r_rd + AW'(1);
                end
                r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // A response with nothing outstanding means the memory side broke ordering.
    always @(posedge i_clk) begin
        if (!i_rst && io_bus.mem_rsp_valid) begin
            assert (r_out != '0);
        end
    end
endmodule
